// File: rtl/tc_pkg.sv
// tc_pkg: shared types and constants for the target cache update controller
package tc_pkg;
    localparam int TC_IDX_W   = 8;
    localparam int TC_ENTRIES = 256;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic [3:0]  bhr;
    } tc_upd_t;

    typedef enum logic {TC_IDLE, TC_CLEAR} tc_state_e;

    function automatic logic [TC_IDX_W-1:0] tc_idx(input tc_upd_t u);
        return {u.pc[3:0], u.bhr};
    endfunction
endpackage

// File: rtl/tc_upd_fifo.sv
// tc_upd_fifo: 2-write/1-read update queue with occupancy count; TC_COALESCE_EN merges same-index updates into queued non-head entries
module tc_upd_fifo
    import tc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          pop,
    input  logic          push0,
    input  logic          push1,
    input  tc_upd_t       d0,
    input  tc_upd_t       d1,
    output tc_upd_t       head,
    output logic [CW-1:0] count,
    output logic          hit0,
    output logic          hit1,
    output logic          hit10
);
    localparam int AW = $clog2(DEPTH);

    tc_upd_t          mem_q [DEPTH];
    tc_upd_t          mem_d [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d, wr1;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] m0, m1;
    logic             n0, n1;

`ifdef TC_COALESCE_EN
    // flag queued entries behind the head whose index matches an incoming update
    always_comb begin
        m0 = '0;
        m1 = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (AW'(AW'(s) - rd_q) != '0 && CW'(AW'(AW'(s) - rd_q)) < cnt_q) begin
                m0[s] = tc_idx(mem_q[s]) == tc_idx(d0);
                m1[s] = tc_idx(mem_q[s]) == tc_idx(d1);
            end
        end
    end
    assign hit0  = |m0;
    assign hit1  = |m1;
    assign hit10 = push0 && !hit0 && tc_idx(d0) == tc_idx(d1);
`else
    assign m0    = '0;
    assign m1    = '0;
    assign hit0  = 1'b0;
    assign hit1  = 1'b0;
    assign hit10 = 1'b0;
`endif

    // next queue contents: in-place merges, then BU0 slot, then BU1 slot
    always_comb begin
        n0    = push0 && !hit0;
        n1    = push1 && !hit1 && !hit10;
        wr1   = wr_q + AW'(n0);
        mem_d = mem_q;
        for (int s = 0; s < DEPTH; s++) begin
            if (push0 && m0[s]) mem_d[s].target = d0.target;
            if (push1 && m1[s]) mem_d[s].target = d1.target;
        end
        if (n0) mem_d[wr_q] = d0;
        if (n1) mem_d[wr1] = d1;
        if (push1 && hit10) mem_d[wr_q].target = d1.target;
        rd_d  = flush ? '0 : rd_q + AW'(pop);
        wr_d  = flush ? '0 : wr1 + AW'(n1);
        cnt_d = flush ? '0 : cnt_q + CW'(n0) + CW'(n1) - CW'(pop);
    end

    // queue storage and pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!resetn) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;
endmodule

// File: rtl/target_cache_update_ctrl.sv
// target_cache_update_ctrl: serialises BU0/BU1 target updates into one cache write per cycle and sweeps the cache on clear; TC_COALESCE_EN enables same-index merging
module target_cache_update_ctrl
    import tc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BHR_W      = 4,
    parameter int PCLO_W     = 4
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              bu0_valid,
    input  logic [31:0]                       bu0_pc,
    input  logic [31:0]                       bu0_target,
    input  logic [BHR_W-1:0]                  bu0_bhr,
    output logic                              bu0_ready,
    input  logic                              bu1_valid,
    input  logic [31:0]                       bu1_pc,
    input  logic [31:0]                       bu1_target,
    input  logic [BHR_W-1:0]                  bu1_bhr,
    output logic                              bu1_ready,
    input  logic                              clear_req,
    output logic                              clear_busy,
    output logic                              update_en,
    output logic [31:0]                       update_pc,
    output logic [31:0]                       update_target,
    output logic [BHR_W-1:0]                  update_BHR,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   q_count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [TC_IDX_W:0] IDX_LAST = (TC_IDX_W+1)'(TC_ENTRIES - 1);
    localparam logic [TC_IDX_W:0] IDX_ONE  = (TC_IDX_W+1)'(1);

    tc_state_e       state_q, state_d;
    logic [TC_IDX_W:0] idx_q, idx_d;
    tc_upd_t         upd_q, upd_d, head, d0, d1;
    logic            en_q, en_d;
    logic            idle, pop, flush, hit0, hit1, hit10;
    logic [CW:0]     free;

    assign d0 = '{pc: bu0_pc, target: bu0_target, bhr: bu0_bhr};
    assign d1 = '{pc: bu1_pc, target: bu1_target, bhr: bu1_bhr};

    assign idle      = resetn && state_q == TC_IDLE && !clear_req;
    assign pop       = idle && q_count != '0;
    assign free      = (CW+1)'(FIFO_DEPTH) - (CW+1)'(q_count) + (CW+1)'(pop);
    assign bu0_ready = idle && (free != '0 || hit0);
    assign bu1_ready = idle && (hit1 || hit10 || free > (CW+1)'(bu0_valid && !hit0));
    assign flush     = resetn && state_q == TC_IDLE && clear_req;

    tc_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .pop    (pop),
        .push0  (bu0_valid && bu0_ready),
        .push1  (bu1_valid && bu1_ready),
        .d0     (d0),
        .d1     (d1),
        .head   (head),
        .count  (q_count),
        .hit0   (hit0),
        .hit1   (hit1),
        .hit10  (hit10)
    );

    // FSM next state, sweep counter and registered drain write
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        en_d    = pop;
        upd_d   = pop ? head : '0;
        if (state_q == TC_CLEAR) begin
            idx_d   = idx_q + IDX_ONE;
            state_d = idx_q == IDX_LAST ? TC_IDLE : TC_CLEAR;
        end else if (clear_req) begin
            state_d = TC_CLEAR;
            idx_d   = '0;
        end
    end

    // state, sweep index and drain output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= TC_IDLE;
            idx_q   <= '0;
            en_q    <= 1'b0;
            upd_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            upd_q   <= upd_d;
        end
    end

    assign clear_busy    = state_q == TC_CLEAR;
    assign update_en     = clear_busy || en_q;
    assign update_pc     = clear_busy ? 32'(idx_q[BHR_W +: PCLO_W]) : upd_q.pc;
    assign update_BHR    = clear_busy ? idx_q[BHR_W-1:0] : upd_q.bhr;
    assign update_target = clear_busy ? '0 : upd_q.target;
endmodule

// File: tb/tb_target_cache_update_ctrl.sv
// tb_target_cache_update_ctrl: directed self-checking bench for target_cache_update_ctrl
module tb_target_cache_update_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        bu0_valid, bu1_valid, bu0_ready, bu1_ready;
    logic [31:0] bu0_pc, bu0_target, bu1_pc, bu1_target;
    logic [3:0]  bu0_bhr, bu1_bhr;
    logic        clear_req, clear_busy, update_en;
    logic [31:0] update_pc, update_target;
    logic [3:0]  update_BHR;
    logic [2:0]  q_count;
    int          passed = 0;
    int          total = 0;
    logic [67:0] wq[$];

    always #5 clk = ~clk;

    target_cache_update_ctrl dut (
        .clk(clk), .resetn(resetn),
        .bu0_valid(bu0_valid), .bu0_pc(bu0_pc), .bu0_target(bu0_target), .bu0_bhr(bu0_bhr), .bu0_ready(bu0_ready),
        .bu1_valid(bu1_valid), .bu1_pc(bu1_pc), .bu1_target(bu1_target), .bu1_bhr(bu1_bhr), .bu1_ready(bu1_ready),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .update_en(update_en), .update_pc(update_pc), .update_target(update_target), .update_BHR(update_BHR),
        .q_count(q_count)
    );

    always @(negedge clk) if (resetn && update_en) wq.push_back({update_pc, update_target, update_BHR});

    task nxt;
        @(posedge clk);
        #1;
    endtask

    task smp;
        @(negedge clk);
    endtask

    task drv(input logic v0, input logic [31:0] p0, input logic [31:0] t0, input logic [3:0] b0,
             input logic v1, input logic [31:0] p1, input logic [31:0] t1, input logic [3:0] b1);
        bu0_valid = v0; bu0_pc = p0; bu0_target = t0; bu0_bhr = b0;
        bu1_valid = v1; bu1_pc = p1; bu1_target = t1; bu1_bhr = b1;
    endtask

    task idle_in;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task test_reset;
        resetn = 0; clear_req = 0; idle_in();
        nxt; nxt; smp;
        total++; if (update_en !== 1'b0) $display("FAIL rst_en got=%b exp=0", update_en); else passed++;
        total++; if (clear_busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", clear_busy); else passed++;
        total++; if (q_count !== 3'd0) $display("FAIL rst_qcount got=%0d exp=0", q_count); else passed++;
        total++; if ({bu0_ready, bu1_ready} !== 2'b00) $display("FAIL rst_ready got=%b exp=00", {bu0_ready, bu1_ready}); else passed++;
        total++; if ({update_pc, update_target, update_BHR} !== 68'd0) $display("FAIL rst_fields got=%h exp=0", {update_pc, update_target, update_BHR}); else passed++;
        nxt; resetn = 1; smp;
        total++; if ({bu0_ready, bu1_ready} !== 2'b11) $display("FAIL rst_idle_ready got=%b exp=11", {bu0_ready, bu1_ready}); else passed++;
        nxt;
    endtask

    task test_single;
        drv(1, 32'h1004, 32'h2000, 4'h3, 0, 0, 0, 0); smp;
        total++; if (bu0_ready !== 1'b1) $display("FAIL single_ready got=%b exp=1", bu0_ready); else passed++;
        nxt; idle_in(); smp;
        total++; if ({update_en, q_count} !== 4'b0_001) $display("FAIL single_c1 en/q got=%b exp=0001", {update_en, q_count}); else passed++;
        nxt; smp;
        total++; if (update_en !== 1'b1) $display("FAIL single_en got=%b exp=1", update_en); else passed++;
        total++; if ({update_pc, update_target, update_BHR} !== {32'h1004, 32'h2000, 4'h3}) $display("FAIL single_fields got=%h exp=%h", {update_pc, update_target, update_BHR}, {32'h1004, 32'h2000, 4'h3}); else passed++;
        total++; if (q_count !== 3'd0) $display("FAIL single_qcount got=%0d exp=0", q_count); else passed++;
        nxt; smp;
        total++; if (update_en !== 1'b0) $display("FAIL single_en_after got=%b exp=0", update_en); else passed++;
        nxt;
    endtask

    task test_dual;
        drv(1, 32'h10, 32'hA000, 4'h1, 1, 32'h24, 32'hB000, 4'h2); smp;
        total++; if ({bu0_ready, bu1_ready} !== 2'b11) $display("FAIL dual_ready got=%b exp=11", {bu0_ready, bu1_ready}); else passed++;
        nxt; idle_in(); smp;
        total++; if (q_count !== 3'd2) $display("FAIL dual_qcount got=%0d exp=2", q_count); else passed++;
        nxt; smp;
        total++; if ({update_en, update_target} !== {1'b1, 32'hA000}) $display("FAIL dual_first got=%b/%h exp=1/a000", update_en, update_target); else passed++;
        nxt; smp;
        total++; if ({update_en, update_target} !== {1'b1, 32'hB000}) $display("FAIL dual_second got=%b/%h exp=1/b000", update_en, update_target); else passed++;
        nxt; smp;
        total++; if (update_en !== 1'b0) $display("FAIL dual_en_after got=%b exp=0", update_en); else passed++;
        nxt;
    endtask

    task test_full;
        logic [67:0] got, exp;
        wq.delete();
        for (int c = 0; c < 3; c++) begin
            drv(1, 32'(2*c), 32'(32'h300 + 2*c), 4'(2*c), 1, 32'(2*c+1), 32'(32'h300 + 2*c + 1), 4'(2*c+1)); smp;
            total++; if ({bu0_ready, bu1_ready} !== 2'b11) $display("FAIL full_fill%0d_ready got=%b exp=11", c, {bu0_ready, bu1_ready}); else passed++;
            nxt;
        end
        drv(1, 32'd6, 32'h306, 4'd6, 1, 32'd7, 32'h307, 4'd7); smp;
        total++; if (q_count !== 3'd4) $display("FAIL full_qcount got=%0d exp=4", q_count); else passed++;
        total++; if ({bu0_ready, bu1_ready} !== 2'b10) $display("FAIL full_ready got=%b exp=10", {bu0_ready, bu1_ready}); else passed++;
        nxt; drv(0, 0, 0, 0, 1, 32'd7, 32'h307, 4'd7); smp;
        total++; if ({q_count, bu1_ready} !== 4'b100_1) $display("FAIL full_bu1_alone q/ready got=%b exp=1001", {q_count, bu1_ready}); else passed++;
        nxt; idle_in();
        repeat (8) nxt;
        total++; if (wq.size() != 8) $display("FAIL full_nwrites got=%0d exp=8", wq.size()); else passed++;
        for (int i = 0; i < 8; i++) begin
            got = (i < wq.size()) ? wq[i] : '1;
            exp = {32'(i), 32'(32'h300 + i), 4'(i)};
            total++; if (got !== exp) $display("FAIL full_order%0d got=%h exp=%h", i, got, exp); else passed++;
        end
    endtask

    task test_clear;
        int bad;
        drv(1, 32'h40, 32'h400, 4'd0, 1, 32'h41, 32'h401, 4'd1); nxt;
        drv(1, 32'h42, 32'h402, 4'd2, 1, 32'h43, 32'h403, 4'd3); smp;
        total++; if ({bu0_ready, bu1_ready} !== 2'b11) $display("FAIL clr_fill_ready got=%b exp=11", {bu0_ready, bu1_ready}); else passed++;
        nxt;
        drv(1, 32'h44, 32'h404, 4'd4, 1, 32'h45, 32'h405, 4'd5); clear_req = 1; smp;
        total++; if (q_count !== 3'd3) $display("FAIL clr_pre_qcount got=%0d exp=3", q_count); else passed++;
        total++; if ({bu0_ready, bu1_ready, clear_busy} !== 3'b000) $display("FAIL clr_req_ready/busy got=%b exp=000", {bu0_ready, bu1_ready, clear_busy}); else passed++;
        nxt; clear_req = 0; idle_in(); wq.delete(); bad = 0;
        for (int k = 0; k < 256; k++) begin
            smp;
            if (k == 0) begin
                total++; if ({q_count, clear_busy} !== 4'b000_1) $display("FAIL clr_start q/busy got=%b exp=0001", {q_count, clear_busy}); else passed++;
            end
            if (!(update_en === 1'b1 && update_pc === 32'(k >> 4) && update_BHR === 4'(k) && update_target === 32'd0 && clear_busy === 1'b1 && bu0_ready === 1'b0)) bad++;
            nxt; clear_req = (k == 49);
        end
        clear_req = 0; smp;
        total++; if (bad != 0) $display("FAIL clr_sweep bad_cycles got=%0d exp=0", bad); else passed++;
        total++; if (wq.size() != 256) $display("FAIL clr_nwrites got=%0d exp=256", wq.size()); else passed++;
        total++; if ({clear_busy, update_en, q_count} !== 5'b0) $display("FAIL clr_end busy/en/q got=%b exp=00000", {clear_busy, update_en, q_count}); else passed++;
        nxt; wq.delete();
        drv(1, 32'h58, 32'h5555, 4'd7, 0, 0, 0, 0); smp;
        total++; if (bu0_ready !== 1'b1) $display("FAIL clr_after_ready got=%b exp=1", bu0_ready); else passed++;
        nxt; idle_in(); repeat (4) nxt;
        total++; if (wq.size() != 1) $display("FAIL clr_after_nwrites got=%0d exp=1", wq.size()); else passed++;
        total++; if ((wq.size() > 0 ? wq[0] : 68'd0) !== {32'h58, 32'h5555, 4'd7}) $display("FAIL clr_after_write got=%h exp=%h", (wq.size() > 0 ? wq[0] : 68'd0), {32'h58, 32'h5555, 4'd7}); else passed++;
    endtask

    task test_reset_sweep;
        clear_req = 1; nxt; clear_req = 0;
        repeat (100) nxt;
        smp;
        total++; if ({update_en, update_pc, update_BHR} !== {1'b1, 32'd6, 4'd4}) $display("FAIL rsw_idx100 got=%b/%h/%h exp=1/6/4", update_en, update_pc, update_BHR); else passed++;
        resetn = 0; nxt; resetn = 1; smp;
        total++; if ({update_en, clear_busy} !== 2'b00) $display("FAIL rsw_after en/busy got=%b exp=00", {update_en, clear_busy}); else passed++;
        total++; if ({bu0_ready, q_count} !== 4'b1_000) $display("FAIL rsw_idle ready/q got=%b exp=1000", {bu0_ready, q_count}); else passed++;
        nxt;
    endtask

    task test_coalesce;
        logic [67:0] w1, w2;
        wq.delete();
        drv(1, 32'h50, 32'h77, 4'd0, 1, 32'h1003, 32'h10, 4'd9); nxt;
        drv(1, 32'h2003, 32'h20, 4'd9, 0, 0, 0, 0); smp;
        total++; if (bu0_ready !== 1'b1) $display("FAIL coal_ready got=%b exp=1", bu0_ready); else passed++;
        nxt; idle_in(); smp;
`ifdef TC_COALESCE_EN
        total++; if (q_count !== 3'd1) $display("FAIL coal_qcount got=%0d exp=1", q_count); else passed++;
`else
        total++; if (q_count !== 3'd2) $display("FAIL coal_qcount got=%0d exp=2", q_count); else passed++;
`endif
        repeat (5) nxt;
        w1 = wq.size() > 1 ? wq[1] : 68'd0;
        w2 = wq.size() > 2 ? wq[2] : 68'd0;
`ifdef TC_COALESCE_EN
        total++; if (wq.size() != 2) $display("FAIL coal_nwrites got=%0d exp=2", wq.size()); else passed++;
        total++; if (w1 !== {32'h1003, 32'h20, 4'd9}) $display("FAIL coal_merged got=%h exp=%h", w1, {32'h1003, 32'h20, 4'd9}); else passed++;
`else
        total++; if (wq.size() != 3) $display("FAIL coal_nwrites got=%0d exp=3", wq.size()); else passed++;
        total++; if (w1 !== {32'h1003, 32'h10, 4'd9}) $display("FAIL coal_first got=%h exp=%h", w1, {32'h1003, 32'h10, 4'd9}); else passed++;
        total++; if (w2 !== {32'h2003, 32'h20, 4'd9}) $display("FAIL coal_second got=%h exp=%h", w2, {32'h2003, 32'h20, 4'd9}); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_full();
        test_clear();
        test_reset_sweep();
        test_coalesce();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
